// File: rtl/digit_timer_pkg.sv
// Shared constants and helpers for the digit_timer BCD counter family.
//   BCD_W / SEG_W  : digit and segment field widths
//   SEG_0..SEG_9   : active-low 7-segment codes, seg a = bit 0
//   SEG_BLANK      : all segments off
//   to_bcd()       : binary to 8-digit packed BCD, used for the LIMIT constant
//   div_of()       : prescaler divide ratio from clock and tick rates
package digit_timer_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    // Binary to packed BCD, eight digits, digit 0 in bits [3:0].
    function automatic logic [31:0] to_bcd(input int unsigned value);
        logic [31:0] bcd;
        int unsigned v;
        bcd = '0;
        v   = value;
        for (int i = 0; i < 8; i++) begin
            bcd[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return bcd;
    endfunction

    function automatic int unsigned div_of(input int unsigned clk_hz, input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to active-low 7-segment pattern, combinational.
//   bcd   : 4-bit BCD digit
//   seg_c : active-low segments, seg a = bit 0; codes above 9 are blanked
module seg7_decode
    import digit_timer_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (bcd)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/digit_timer.sv
// Clock-divided tick generator driving a multi-digit BCD up/down counter
// with programmable wrap limit, synchronous load and terminal-count pulse.
// Optional 7-segment outputs are built only when DIGIT_TIMER_SEG_EN is defined.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   en         : run (1) / pause (0); pause holds prescaler phase
//   up_dn      : count direction, 1 = up
//   load       : synchronous load strobe, load_val is BCD (clamped to LIMIT)
//   count_bcd  : registered BCD count
//   tick       : registered one-cycle pulse at the count rate
//   tc         : registered one-cycle pulse coincident with a wrapped count
//   hex        : registered active-low segments per digit (DIGIT_TIMER_SEG_EN)
module digit_timer
    import digit_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1,
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned LIMIT   = 59
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      up_dn,
    input  logic                      load,
    input  logic [BCD_W*DIGITS-1:0]   load_val,
    output logic [BCD_W*DIGITS-1:0]   count_bcd,
    output logic                      tick,
    output logic                      tc
`ifdef DIGIT_TIMER_SEG_EN
    ,
    output logic [SEG_W*DIGITS-1:0]   hex
`endif
);

    localparam int unsigned DIV   = div_of(CLK_HZ, TICK_HZ);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CNT_W = BCD_W * DIGITS;
    localparam logic [CNT_W-1:0] LIMIT_BCD = CNT_W'(to_bcd(LIMIT));
    localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(DIV - 1);

    logic [DIV_W-1:0]  presc;
    logic [CNT_W-1:0]  inc_val;
    logic [CNT_W-1:0]  dec_val;
    logic [DIGITS-1:0] carry;
    logic [DIGITS-1:0] borrow;
    logic [DIGITS-1:0] dig_ok;
    logic              load_ok;
    logic              wrap;

    assign wrap    = (presc == PRESC_MAX);
    assign load_ok = (&dig_ok) && (load_val <= LIMIT_BCD);

    // Per-digit increment/decrement with a ripple carry/borrow chain.
    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [BCD_W-1:0] d;
        assign d         = count_bcd[i*BCD_W +: BCD_W];
        assign dig_ok[i] = (load_val[i*BCD_W +: BCD_W] <= 4'd9);

        assign inc_val[i*BCD_W +: BCD_W] = !carry[i]  ? d :
                                           (d == 4'd9) ? 4'd0 : d + 4'd1;
        assign dec_val[i*BCD_W +: BCD_W] = !borrow[i] ? d :
                                           (d == 4'd0) ? 4'd9 : d - 4'd1;

        if (i < DIGITS - 1) begin : g_chain
            assign carry[i+1]  = carry[i]  && (d == 4'd9);
            assign borrow[i+1] = borrow[i] && (d == 4'd0);
        end
    end

    // Prescaler, tick, counter and terminal count; reset > load > step.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc     <= '0;
            count_bcd <= '0;
            tick      <= 1'b0;
            tc        <= 1'b0;
        end else if (load) begin
            presc     <= '0;
            count_bcd <= load_ok ? load_val : LIMIT_BCD;
            tick      <= 1'b0;
            tc        <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (en) begin
                presc <= wrap ? '0 : presc + DIV_W'(1);
                tick  <= wrap;
            end else begin
                tick  <= 1'b0;
            end
            if (tick && en) begin
                if (up_dn) begin
                    if (count_bcd == LIMIT_BCD) begin
                        count_bcd <= '0;
                        tc        <= 1'b1;
                    end else begin
                        count_bcd <= inc_val;
                    end
                end else begin
                    if (count_bcd == '0) begin
                        count_bcd <= LIMIT_BCD;
                        tc        <= 1'b1;
                    end else begin
                        count_bcd <= dec_val;
                    end
                end
            end
        end
    end

`ifdef DIGIT_TIMER_SEG_EN
    logic [SEG_W*DIGITS-1:0] seg_c;

    for (genvar i = 0; i < DIGITS; i++) begin : g_seg
        seg7_decode u_dec (
            .bcd   (count_bcd[i*BCD_W +: BCD_W]),
            .seg_c (seg_c[i*SEG_W +: SEG_W])
        );
    end

    // Segment register: one cycle behind count_bcd.
    always_ff @(posedge clk) begin
        if (reset) begin
            hex <= {DIGITS{SEG_0}};
        end else begin
            hex <= seg_c;
        end
    end
`endif

endmodule
